// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifetch_pkg;

  localparam int FQ_PC_W  = 9;
  localparam int FQ_INS_W = 32;

  localparam logic [FQ_INS_W-1:0] NOP_INSTR = 32'h0;
  localparam int                  PC_STEP   = 4;

  typedef struct packed {
    logic [FQ_PC_W-1:0]  pc;
    logic [FQ_INS_W-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-side bundle: pipeline control, instruction-memory handshake and decode-facing outputs.
interface ifetch_queue_if
  import ifetch_pkg::*;
#(
  parameter int PC_W  = FQ_PC_W,
  parameter int INS_W = FQ_INS_W
);

  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic             stall;

  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [INS_W-1:0] imem_rdata;

  logic             if_valid;
  logic [PC_W-1:0]  if_pc;
  logic [INS_W-1:0] if_instr;

  modport master (
    input  redirect, redirect_pc, stall, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, if_valid, if_pc, if_instr
  );

  modport slave (
    output redirect, redirect_pc, stall, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_pc, if_instr
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; push while full is accepted only together with a pop.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: credit-limited requests, in-order response buffering, squash on redirect.
// Define IFETCH_BYPASS_EN to present a response to decode in the same cycle when the queue is empty.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int              PC_W     = FQ_PC_W,
  parameter int              INS_W    = FQ_INS_W,
  parameter int              FQ_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           reset,
  ifetch_queue_if.master bus
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [PC_W-1:0] fetch_pc;
  logic [CW-1:0]   drop_cnt;
  logic            run;
  logic            grant;
  logic            resp_keep;
  logic [CW:0]     credits_used;

  logic            aq_full, aq_empty;
  logic [PC_W-1:0] aq_head;
  logic [CW-1:0]   in_flight;

  logic            iq_push, iq_pop, iq_full, iq_empty;
  fq_entry_t       iq_wdata, iq_head;
  logic [CW-1:0]   occupancy;

  // Queued plus outstanding words never exceed FQ_DEPTH, so neither FIFO can overflow.
  assign credits_used = {1'b0, occupancy} + {1'b0, in_flight};
  assign bus.imem_req  = run && !reset && !bus.redirect &&
                         (credits_used < (CW+1)'(FQ_DEPTH));
  assign bus.imem_addr = fetch_pc;
  assign grant         = bus.imem_req && bus.imem_gnt;
  assign resp_keep     = bus.imem_rvalid && (drop_cnt == '0) && !bus.redirect;

  assign iq_wdata.pc    = aq_head;
  assign iq_wdata.instr = bus.imem_rdata;
  assign iq_pop         = !iq_empty && !bus.stall;

`ifdef IFETCH_BYPASS_EN
  logic bypass;
  assign bypass  = resp_keep && iq_empty;
  assign iq_push = resp_keep && !(bypass && !bus.stall);
`else
  assign iq_push = resp_keep;
`endif

  always_comb begin
    bus.if_valid = 1'b0;
    bus.if_pc    = '0;
    bus.if_instr = NOP_INSTR;
    if (!iq_empty) begin
      bus.if_valid = 1'b1;
      bus.if_pc    = iq_head.pc;
      bus.if_instr = iq_head.instr;
    end
`ifdef IFETCH_BYPASS_EN
    else if (bypass) begin
      bus.if_valid = 1'b1;
      bus.if_pc    = aq_head;
      bus.if_instr = bus.imem_rdata;
    end
`endif
  end

  // run keeps imem_req low for the first cycle after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
      run      <= 1'b0;
    end else begin
      run <= 1'b1;
      if (bus.redirect) begin
        fetch_pc <= bus.redirect_pc & ~PC_W'(3);
        drop_cnt <= in_flight - CW'(bus.imem_rvalid);
      end else begin
        if (grant) fetch_pc <= fetch_pc + PC_W'(PC_STEP);
        if (bus.imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && bus.imem_rvalid) assert (!aq_empty);
    if (!reset && grant)           assert (!aq_full || bus.imem_rvalid);
    if (!reset && iq_push)         assert (!iq_full || iq_pop);
  end

  // Address FIFO is never cleared so responses stay paired with their request PCs.
  fetch_fifo #(.WIDTH(PC_W), .DEPTH(FQ_DEPTH)) u_addr_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (grant),
    .pop     (bus.imem_rvalid),
    .clear   (1'b0),
    .wr_data (fetch_pc),
    .rd_data (aq_head),
    .full    (aq_full),
    .empty   (aq_empty),
    .count   (in_flight)
  );

  fetch_fifo #(.WIDTH($bits(fq_entry_t)), .DEPTH(FQ_DEPTH)) u_instr_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (iq_push),
    .pop     (iq_pop),
    .clear   (bus.redirect),
    .wr_data (iq_wdata),
    .rd_data (iq_head),
    .full    (iq_full),
    .empty   (iq_empty),
    .count   (occupancy)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a variable-latency in-order instruction memory model.
module tb_ifetch_queue;
  import ifetch_pkg::*;

  typedef struct {
    logic       st;
    logic       gn;
    logic       ev;
    logic [8:0] epc;
    logic       er;
    logic [8:0] ea;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ifetch_queue_if bus ();

  ifetch_queue dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;
  int         pend_due[$];
  logic [8:0] pend_addr[$];

  logic        o_valid, o_req;
  logic [8:0]  o_pc, o_addr;
  logic [31:0] o_instr;

  function automatic logic [31:0] mem_word(logic [8:0] a);
    return 32'hA500_0013 ^ ({23'h0, a} << 7);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: present memory response, sample outputs, then advance past the edge.
  task automatic step();
    if (!reset && pend_due.size() > 0 && pend_due[0] <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pend_addr[0]);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
    end
    #1;
    o_valid = bus.if_valid;
    o_pc    = bus.if_pc;
    o_instr = bus.if_instr;
    o_req   = bus.imem_req;
    o_addr  = bus.imem_addr;
    @(posedge clk);
    if (reset) begin
      pend_due.delete();
      pend_addr.delete();
    end else begin
      if (bus.imem_rvalid) begin
        void'(pend_due.pop_front());
        void'(pend_addr.pop_front());
      end
      if (o_req && bus.imem_gnt) begin
        pend_due.push_back(cyc + lat);
        pend_addr.push_back(o_addr);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.stall       = 1'b0;
    bus.imem_gnt    = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[19];
    logic [8:0] exp_seq[4];
    int         n;
    int         first_k;

    reset           = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.stall       = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    @(negedge clk);

    // Streaming with 1-cycle memory, then a 6-cycle stall holding PC 0x10.
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 9'h000};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 9'h000, 1'b1, 9'h000};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 9'h000, 1'b1, 9'h004};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 9'h000, 1'b1, 9'h008};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 9'h004, 1'b1, 9'h00C};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 9'h008, 1'b1, 9'h010};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 9'h00C, 1'b1, 9'h014};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 9'h010, 1'b1, 9'h018};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 9'h010, 1'b1, 9'h01C};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 9'h010, 1'b0, 9'h000};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 9'h010, 1'b0, 9'h000};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 9'h010, 1'b0, 9'h000};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 9'h010, 1'b0, 9'h000};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 9'h010, 1'b0, 9'h000};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 9'h014, 1'b1, 9'h020};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 9'h018, 1'b1, 9'h024};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 9'h01C, 1'b1, 9'h028};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 9'h020, 1'b1, 9'h02C};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 9'h024, 1'b1, 9'h030};

    lat = 1;
    do_reset();
    for (int i = 0; i < 19; i++) begin
      bus.stall    = tbl[i].st;
      bus.imem_gnt = tbl[i].gn;
      step();
      chk($sformatf("t%0d.valid", i), 32'(o_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("t%0d.pc", i), 32'(o_pc), 32'(tbl[i].epc));
        chk($sformatf("t%0d.instr", i), o_instr, mem_word(tbl[i].epc));
      end else begin
        chk($sformatf("t%0d.instr0", i), o_instr, 32'h0);
      end
      if (i == 0) chk("reset.pc", 32'(o_pc), 32'h0);
      chk($sformatf("t%0d.req", i), 32'(o_req), 32'(tbl[i].er));
      if (tbl[i].er) chk($sformatf("t%0d.addr", i), 32'(o_addr), 32'(tbl[i].ea));
    end
    bus.stall = 1'b0;

    // Three requests in flight at latency 3, then redirect to 0x80.
    lat = 3;
    do_reset();
    bus.redirect = 1'b1; bus.redirect_pc = 9'h020;
    step();
    chk("rd.c0.req", 32'(o_req), 32'h0);
    bus.redirect = 1'b0;
    step();
    chk("rd.c1.req", 32'(o_req), 32'h1);
    chk("rd.c1.addr", 32'(o_addr), 32'h020);
    step();
    chk("rd.c2.addr", 32'(o_addr), 32'h024);
    step();
    chk("rd.c3.addr", 32'(o_addr), 32'h028);
    bus.redirect = 1'b1; bus.redirect_pc = 9'h080;
    step();
    chk("rd.c4.req", 32'(o_req), 32'h0);
    bus.redirect = 1'b0;
    step();
    chk("rd.c5.req", 32'(o_req), 32'h1);
    chk("rd.c5.addr", 32'(o_addr), 32'h080);
    chk("rd.c5.valid", 32'(o_valid), 32'h0);
    exp_seq[0] = 9'h080; exp_seq[1] = 9'h084; exp_seq[2] = 9'h088; exp_seq[3] = 9'h08C;
    n = 0;
    first_k = -1;
    for (int k = 0; k < 16 && n < 3; k++) begin
      step();
      if (o_valid) begin
        if (n == 0) first_k = k;
        chk($sformatf("rd.pc%0d", n), 32'(o_pc), 32'(exp_seq[n]));
        chk($sformatf("rd.instr%0d", n), o_instr, mem_word(exp_seq[n]));
        n++;
      end
    end
    chk("rd.first_valid_cycle", 32'(first_k), 32'd3);
    chk("rd.count", 32'(n), 32'd3);

    // Redirect address low bits are ignored; back-to-back redirects, last wins.
    lat = 1;
    do_reset();
    bus.redirect = 1'b1; bus.redirect_pc = 9'h040;
    step();
    bus.redirect_pc = 9'h103;
    step();
    chk("al.c1.req", 32'(o_req), 32'h0);
    bus.redirect = 1'b0;
    step();
    chk("al.c2.req", 32'(o_req), 32'h1);
    chk("al.c2.addr", 32'(o_addr), 32'h100);
    step();
    step();
    chk("al.c4.valid", 32'(o_valid), 32'h1);
    chk("al.c4.pc", 32'(o_pc), 32'h100);

    // Fetch PC wraps from 0x1FC to 0x000.
    do_reset();
    bus.redirect = 1'b1; bus.redirect_pc = 9'h1F8;
    step();
    bus.redirect = 1'b0;
    step();
    chk("wr.c1.addr", 32'(o_addr), 32'h1F8);
    step();
    chk("wr.c2.addr", 32'(o_addr), 32'h1FC);
    exp_seq[0] = 9'h1F8; exp_seq[1] = 9'h1FC; exp_seq[2] = 9'h000; exp_seq[3] = 9'h004;
    n = 0;
    for (int k = 0; k < 12 && n < 4; k++) begin
      step();
      if (k == 0) begin
        chk("wr.c3.req", 32'(o_req), 32'h1);
        chk("wr.c3.addr", 32'(o_addr), 32'h000);
      end
      if (o_valid) begin
        chk($sformatf("wr.pc%0d", n), 32'(o_pc), 32'(exp_seq[n]));
        chk($sformatf("wr.instr%0d", n), o_instr, mem_word(exp_seq[n]));
        n++;
      end
    end
    chk("wr.count", 32'(n), 32'd4);

    // Reset while the queue is full and stalled.
    do_reset();
    bus.stall = 1'b1;
    for (int k = 0; k < 10; k++) step();
    chk("rf.full.req", 32'(o_req), 32'h0);
    chk("rf.full.valid", 32'(o_valid), 32'h1);
    chk("rf.full.pc", 32'(o_pc), 32'h000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("rf.after.valid", 32'(o_valid), 32'h0);
    chk("rf.after.req", 32'(o_req), 32'h0);
    chk("rf.after.pc", 32'(o_pc), 32'h0);
    chk("rf.after.instr", o_instr, 32'h0);
    bus.stall = 1'b0;
    step();
    chk("rf.first.req", 32'(o_req), 32'h1);
    chk("rf.first.addr", 32'(o_addr), 32'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end that sits upstream of the IF/ID pipeline register.
- Generates the fetch PC and issues requests to an instruction memory that uses a grant/response handshake with variable latency.
- Buffers returned instructions in a small in-order queue and presents them, with their PC, to decode.
- Absorbs the pipeline's stall (load-use hazard) and redirect/flush (taken branch, jal, jalr) signals; returned words from squashed requests are discarded.

Parameters:
- PC_W, 9, program counter / instruction address width (byte address).
- INS_W, 32, instruction width.
- FQ_DEPTH, 4, instruction queue entries; also the limit on in-flight plus queued fetches; power of two, ≥2.
- RESET_PC, 0, fetch PC after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- redirect  in  1  flush and redirect fetch (branch unit PcSel)
- redirect_pc  in  PC_W  new fetch address; bits [1:0] ignored (treated as 0)
- stall  in  1  decode not accepting this cycle (Reg_Stall)
- imem_req  out  1  fetch request valid
- imem_addr  out  PC_W  fetch address
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response data valid (in-order, one per granted request)
- imem_rdata  in  INS_W  response instruction
- if_valid  out  1  if_pc/if_instr hold a valid instruction
- if_pc  out  PC_W  PC of presented instruction
- if_instr  out  INS_W  presented instruction; 0 when if_valid=0

Behaviour:
- Single clock. Reset is synchronous and active-high; all state updates on posedge clk.
- Reset: fetch_pc=RESET_PC, queue empty, in-flight=0, drop_cnt=0. Outputs: if_valid=0, if_pc=0, if_instr=0, imem_req=0 in the cycle after reset.
- Reset mid-operation wins over every other input. Responses arriving after reset for pre-reset requests are not supported; the memory is reset together with this block.
- Issue: imem_req=1 when (occupancy + in_flight) < FQ_DEPTH and redirect=0; imem_addr=fetch_pc.
- On imem_req && imem_gnt:
  - fetch_pc += 4, modulo 2^PC_W; wrap from 2^PC_W-4 to 0 is legal.
  - fetch_pc is pushed to the internal address FIFO.
  - in_flight increments.
- Response: on imem_rvalid, pop the address FIFO.
  - If drop_cnt>0: decrement drop_cnt; the word is discarded.
  - Otherwise: push {pc, instr} to the queue.
  - in_flight decrements.
- Output: the queue head drives if_pc/if_instr. if_valid = !empty. The head is popped when if_valid && !stall.
- Latency: rvalid in cycle N gives if_valid in cycle N+1 (no bypass). The address-to-request path is combinational from fetch_pc.
- Simultaneous push and pop on a full queue is legal; occupancy is unchanged.
- Credit rule guarantees no overflow. Response when in_flight==0 is an error; flag it with a simulation assertion.
- redirect=1, cycle N:
  - fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00}; the queue is cleared.
  - drop_cnt <= in_flight minus any response consumed in N; address FIFO entries stay aligned.
  - imem_req=0 in cycle N.
  - if_valid=0 in N+1; the first request to the new PC is issued in N+1.
- Redirect and stall in the same cycle: redirect wins.
- Redirect and grant in the same cycle: cannot occur, because req is forced to 0.
- Back-to-back redirects: the last one wins; drop_cnt accumulates correctly.
- Stall holds the head stable; fetching continues until credits are exhausted.

Optional Feature:
- Macro: IFETCH_BYPASS_EN.
- When defined: if the queue is empty, drop_cnt==0, redirect==0 and imem_rvalid=1, the response is presented combinationally the same cycle (if_valid=1, if_instr=imem_rdata).
  - If also !stall, it is consumed without entering the queue.
  - If stall, it is enqueued as normal.
  - Latency is 0 cycles from rvalid.
- When undefined: 1-cycle latency as above; no combinational path from imem_* to if_*.

Decomposition:
- Package ifetch_pkg holds:
  - fq_entry_t struct {logic [PC_W-1:0] pc; logic [INS_W-1:0] instr;}
  - localparam NOP_INSTR = 32'h0
  - localparam PC_STEP = 4
- Sub-module fetch_fifo: parameterised synchronous FIFO (WIDTH, DEPTH) with push/pop/clear, full/empty and count outputs.
  - Instantiated twice: the address FIFO (width PC_W) and the instruction queue (fq_entry_t).

Test Plan:
- Reset, then gnt=1 and 1-cycle memory latency, stall=0 → if_pc sequence 0,4,8,12,… on consecutive cycles after 2-cycle fill; if_instr matches memory.
- stall=1 for 6 cycles mid-stream → if_pc holds (e.g. 0x10); imem_req drops once 4 entries/in-flight are used; after release, 0x10,0x14,… resume with no gap or duplicate.
- 3 requests in flight (0x20,0x24,0x28, latency 3), redirect to 0x80 → those 3 responses discarded; next if_valid shows if_pc=0x80.
- redirect with redirect_pc=0x103 → next imem_addr=0x100.
- fetch_pc=0x1FC, gnt=1 → next imem_addr=0x000; if_pc after 0x1FC is 0x000.
- Assert reset while queue is full and stalled → next cycle if_valid=0, imem_req=0; after release, first imem_addr=RESET_PC.
